// File: rtl/half_adder_pkg.sv
// Shared definitions for the half_adder block.
// Contents: lane-count limit, default counter width, per-lane result struct.
package half_adder_pkg;

  localparam int unsigned WIDTH_MAX     = 64;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Combinational result of one half-adder lane
  typedef struct packed {
    logic sum;
    logic carry;
  } ha_res_t;

endpackage

// File: rtl/ha_cell.sv
// Purely combinational 1-bit half adder.
// Ports: a, b  - addend bits
//        res_c - {sum, carry} for this lane (combinational)
module ha_cell
  import half_adder_pkg::*;
(
  input  logic    a,
  input  logic    b,
  output ha_res_t res_c
);

  always_comb begin
    res_c       = '0;
    res_c.sum   = a ^ b;
    res_c.carry = a & b;
  end

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane registered half adder with optional operation statistics.
// Ports: clk, rst_n           - clock, async-assert active-low reset
//        in_valid, a, b       - operation qualifier and per-lane addends
//        sum, carry, out_valid- registered results, valid one cycle after accept
//        stats_clr, op_cnt, carry_cnt - statistics (only with HALF_ADDER_STATS_EN)
// Config: define HALF_ADDER_STATS_EN to include the statistics counters.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  ha_res_t [WIDTH-1:0] res_c;
  logic    [WIDTH-1:0] sum_c;
  logic    [WIDTH-1:0] carry_c;
  logic    [1:0]       rst_sync_q;
  logic                rst_rdy_c;
  logic                accept_c;

  // Lane array
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .res_c (res_c[i])
    );
    assign sum_c[i]   = res_c[i].sum;
    assign carry_c[i] = res_c[i].carry;
  end

  // Reset release synchroniser: clears instantly, releases on clk edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Stage 1 opens acceptance from the second edge after release; stage 2
  // holds it open once the release has settled through both flops.
  assign rst_rdy_c = rst_sync_q[0] | rst_sync_q[1];
  assign accept_c  = in_valid & rst_rdy_c;

  // Result registers: load only on accept so idle-cycle inputs never reach outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept_c;
      if (accept_c) begin
        sum   <= sum_c;
        carry <= carry_c;
      end
    end
  end

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic any_carry_c;
  assign any_carry_c = |carry_c;

  // Saturating statistics counters; clear takes priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt    <= '0;
      carry_cnt <= '0;
    end else if (stats_clr) begin
      op_cnt    <= '0;
      carry_cnt <= '0;
    end else if (accept_c) begin
      if (op_cnt != CNT_MAX) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
      if (any_carry_c && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a 1-lane and an 8-lane instance share
// stimulus; an arithmetic reference model predicts every output each cycle.
module tb_half_adder;

  localparam int CMAX = 15;  // saturation value of the 4-bit counters on the 8-lane DUT

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic       stats_clr;

  logic       s1, c1, v1;
  logic [7:0] s8, c8;
  logic       v8;
  logic [15:0] op1, cc1;
  logic [3:0]  op8, cc8;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_sum, m_carry;
  logic       m_valid;
  int         m_edges;
  int         m_op, m_cc;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a8[0:0]),
    .b         (b8[0:0]),
    .sum       (s1),
    .carry     (c1),
    .out_valid (v1)
`ifdef HALF_ADDER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .op_cnt    (op1),
    .carry_cnt (cc1)
`endif
  );

  half_adder #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a8),
    .b         (b8),
    .sum       (s8),
    .carry     (c8),
    .out_valid (v8)
`ifdef HALF_ADDER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .op_cnt    (op8),
    .carry_cnt (cc8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid8", 64'(v8), 64'(m_valid));
    check("sum8",       64'(s8), 64'(m_sum));
    check("carry8",     64'(c8), 64'(m_carry));
    check("out_valid1", 64'(v1), 64'(m_valid));
    check("sum1",       64'(s1), 64'(m_sum[0]));
    check("carry1",     64'(c1), 64'(m_carry[0]));
`ifdef HALF_ADDER_STATS_EN
    check("op_cnt8",    64'(op8), 64'(m_op));
    check("carry_cnt8", 64'(cc8), 64'(m_cc));
`endif
  endtask

  task automatic model_reset();
    m_sum   = '0;
    m_carry = '0;
    m_valid = 1'b0;
    m_edges = 0;
    m_op    = 0;
    m_cc    = 0;
  endtask

  // Predict the effect of the coming edge, take it, then compare
  task automatic cycle();
    int   s;
    logic acc;
    logic any;
    m_edges++;
    acc = (in_valid === 1'b1) && (m_edges >= 2);
    any = 1'b0;
    m_valid = acc;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        s = int'(a8[i]) + int'(b8[i]);
        m_sum[i]   = (s % 2) == 1;
        m_carry[i] = (s / 2) == 1;
        if (s == 2) any = 1'b1;
      end
    end
`ifdef HALF_ADDER_STATS_EN
    if (stats_clr) begin
      m_op = 0;
      m_cc = 0;
    end else if (acc) begin
      m_op = (m_op + 1 > CMAX) ? CMAX : m_op + 1;
      if (any) m_cc = (m_cc + 1 > CMAX) ? CMAX : m_cc + 1;
    end
`endif
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic exp_s[4];
    logic exp_c[4];
    logic [1:0] ab;
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a8        = '0;
    b8        = '0;
    stats_clr = 1'b0;
    model_reset();

    // Reset state
    #12;
    compare_all();
    rst_n = 1'b1;

    // Release timing: first edge ignored, second edge accepts
    in_valid = 1'b1;
    a8 = 8'h01;
    b8 = 8'h01;
    cycle();
    cycle();

    // Truth table on successive cycles
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      a8 = {7'b0, ab[1]};
      b8 = {7'b0, ab[0]};
      cycle();
      check("tt_sum",   64'(s1), 64'(exp_s[k]));
      check("tt_carry", 64'(c1), 64'(exp_c[k]));
      check("tt_valid", 64'(v1), 64'(1));
    end

    // Wide pattern
    a8 = 8'hF0;
    b8 = 8'hCC;
    cycle();
    check("wide_sum",   64'(s8), 64'h3C);
    check("wide_carry", 64'(c8), 64'hC0);

    // Idle with toggling and unknown inputs: outputs hold
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a8 = (k % 2 == 1) ? 8'hxx : 8'h55;
      b8 = (k % 2 == 1) ? 8'hAA : 8'hxx;
      cycle();
    end
    check("hold_sum8", 64'(s8), 64'h3C);

`ifdef HALF_ADDER_STATS_EN
    // Clear wins over a simultaneous accept; result still produced
    stats_clr = 1'b1;
    in_valid  = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    cycle();
    check("clr_op",    64'(op8), 64'(0));
    check("clr_cc",    64'(cc8), 64'(0));
    check("clr_valid", 64'(v8),  64'(1));
    stats_clr = 1'b0;

    // Saturation
    a8 = 8'h01;
    b8 = 8'h01;
    for (int k = 0; k < 20; k++) cycle();
    check("sat_op", 64'(op8), 64'(15));
    check("sat_cc", 64'(cc8), 64'(15));
    stats_clr = 1'b1;
    in_valid  = 1'b0;
    cycle();
    stats_clr = 1'b0;
`endif

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom % 4) != 0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
`ifdef HALF_ADDER_STATS_EN
      stats_clr = ($urandom % 32) == 0;
`endif
      cycle();
    end
    stats_clr = 1'b0;

    // Reset pulse between edges with an operation pending
    in_valid = 1'b1;
    a8 = 8'hFF;
    b8 = 8'h0F;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    rst_n = 1'b1;
    cycle();
    check("rst_no_valid", 64'(v8), 64'(0));
    cycle();
    check("rst_resume_sum", 64'(s8), 64'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-adder lanes; legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters; legal range 4..32.
REQ-003 clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 in_valid, input, 1: qualifies a and b in the current cycle.
REQ-006 a, input, WIDTH: first addend, one bit per lane.
REQ-007 b, input, WIDTH: second addend, one bit per lane.
REQ-008 sum, output, WIDTH: registered per-lane sum bit.
REQ-009 carry, output, WIDTH: registered per-lane carry bit.
REQ-010 out_valid, output, 1: sum and carry hold a fresh result this cycle.
REQ-011 stats_clr, input, 1: synchronous clear of the statistics counters (HALF_ADDER_STATS_EN only).
REQ-012 op_cnt, output, CNT_W: count of accepted operations (HALF_ADDER_STATS_EN only).
REQ-013 carry_cnt, output, CNT_W: count of accepted operations with any carry bit set (HALF_ADDER_STATS_EN only).

Function
REQ-014 Per lane i: sum[i] SHALL be a[i] XOR b[i], and carry[i] SHALL be a[i] AND b[i].
REQ-015 Results SHALL appear exactly 1 cycle after the edge on which in_valid=1; out_valid SHALL pulse high for that one cycle.
REQ-016 When in_valid=0: sum and carry SHALL hold their last values, and out_valid SHALL be 0 on the next cycle.
REQ-017 Back-to-back in_valid=1 cycles SHALL be accepted every cycle, with no stall and no backpressure.
REQ-018 op_cnt SHALL increment by 1 per accepted operation.
REQ-019 carry_cnt SHALL increment by 1 per accepted operation where |(a & b) is 1.
REQ-020 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-021 If stats_clr and in_valid are both 1 in the same cycle, clear wins: counters become 0, and that operation is not counted.
REQ-022 X on a or b while in_valid=0 SHALL NOT propagate to any output.

Reset
REQ-023 While rst_n=0: sum=0, carry=0, out_valid=0, op_cnt=0, carry_cnt=0, applied immediately, without waiting for a clock edge.
REQ-024 Deassertion of rst_n SHALL be synchronous to clk through the design's 2-flop reset synchroniser.
REQ-025 The first operation SHALL be accepted on the second rising edge after rst_n rises.
REQ-026 An operation in flight when reset asserts SHALL be discarded, and out_valid SHALL NOT pulse for it.

Configuration
REQ-027 Macro HALF_ADDER_STATS_EN defined: stats_clr, op_cnt, carry_cnt and the counter logic are present.
REQ-028 Macro HALF_ADDER_STATS_EN undefined: those ports and that logic are absent; REQ-014..017 are unchanged.

Structure
REQ-029 Package half_adder_pkg SHALL hold WIDTH_MAX=64, CNT_W_DEFAULT=16, and a typedef for the per-lane result struct {sum, carry}.
REQ-030 One sub-module, ha_cell, SHALL be a combinational 1-bit half adder, instantiated WIDTH times via generate.
REQ-031 half_adder SHALL own the registers, the reset synchroniser and the counters.

Verification
REQ-032 WIDTH=1, with in_valid=1, apply a/b = 0/0, 0/1, 1/0, 1/1 on successive cycles -> sum/carry = 0/0, 1/0, 1/0, 0/1, each 1 cycle later, with out_valid high for each.
REQ-033 WIDTH=8, a=8'hF0, b=8'hCC -> sum=8'h3C and carry=8'hC0 after 1 cycle.
REQ-034 Pulse rst_n low mid-operation, with no clock edge during the pulse -> all outputs 0 immediately and no out_valid for the in-flight operation.
REQ-035 With HALF_ADDER_STATS_EN and CNT_W=4, apply 20 operations with a=b=1 -> op_cnt=15 and carry_cnt=15 (saturated).
REQ-036 With HALF_ADDER_STATS_EN, assert stats_clr and in_valid in the same cycle -> counters=0 next cycle, while the result is still output.
REQ-037 With in_valid=0 and a/b toggling -> outputs hold and out_valid stays 0.
